mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
Sequencer for one 8x8 MAC with a saturating 16-bit accumulator. It runs one biased dot product of length LEN per START.
- Reads operand pairs from a shared 1-cycle-latency operand RAM.
- Drives the MAC control and operand pins: bias load, then LEN accumulate cycles.
- Captures the MAC output and presents it on a valid/ready result port.
- Sits between the NPU layer scheduler (START/RESULT) and one MAC lane.

Parameters:
VEC_LEN, 16, maximum dot-product length; LEN values above this are clamped to it.
ADDR_W, 4, operand RAM address width; VEC_LEN <= 2**ADDR_W.

Ports:
CLKEXT  in  1  clock, rising edge
RST_N  in  1  synchronous active-low reset
START  in  1  start request, sampled in IDLE (or HOLD together with RESULT_READY)
LEN  in  ADDR_W+1  vector length, sampled with START; 0 means bias only
BIAS  in  8  unsigned bias, sampled with START
RD_EN  out  1  operand RAM read strobe
RD_ADDR  out  ADDR_W  operand RAM address
RD_A  in  8  signed operand A; valid the cycle after RD_EN
RD_B  in  8  signed operand B; valid the cycle after RD_EN
EN_MAC  out  1  MAC register enable
RST_MAC  out  1  MAC mux select; 1 loads bias, 0 accumulates
BIAS_OUT  out  8  bias to MAC
A_OUT  out  8  signed operand A to MAC
B_OUT  out  8  signed operand B to MAC
MAC_Y  in  16  signed MAC accumulator output
BUSY  out  1  high in every state except IDLE
RESULT  out  16  captured signed result
RESULT_VALID  out  1  result available
RESULT_READY  in  1  consumer accepts result

Behaviour:
- Reset (RST_N=0 at a CLKEXT edge):
  - State goes to IDLE.
  - All outputs go to 0, including RESULT and the latched LEN, BIAS and counter.
  - Reset mid-operation abandons the job; no partial result is emitted.
- States: IDLE, LOAD, ACCUM, CAPTURE, HOLD. Outputs are decoded from the state and registers; A_OUT/B_OUT pass RD_A/RD_B straight through in ACCUM and are 0 elsewhere.
- IDLE:
  - START=1 latches BIAS and len = min(LEN, VEC_LEN), clears idx, and moves to LOAD.
  - START is ignored in every other state, except HOLD as described below.
- LOAD (1 cycle):
  - Drives EN_MAC=1, RST_MAC=1, BIAS_OUT=latched bias.
  - If len>0: RD_EN=1, RD_ADDR=0, next state ACCUM.
  - If len=0: next state CAPTURE.
- ACCUM (len cycles, idx = 0..len-1):
  - Drives EN_MAC=1, RST_MAC=0, A_OUT=RD_A, B_OUT=RD_B.
  - If idx+1 < len: RD_EN=1, RD_ADDR=idx+1.
  - At idx = len-1 the next state is CAPTURE.
- CAPTURE (1 cycle):
  - EN_MAC=0 and RD_EN=0.
  - RESULT <= MAC_Y; next state HOLD.
- HOLD:
  - RESULT_VALID=1; RESULT stays stable until the handshake.
  - RESULT_READY=1 completes the handshake and the next state is IDLE.
  - If START=1 in that same cycle, the new job is accepted and the next state is LOAD (back-to-back).
- Latency: START accepted in cycle 0 gives RESULT_VALID first high in cycle len+3. len=0 gives cycle 3.
- EN_MAC is 0 in IDLE, CAPTURE and HOLD, so the MAC holds its value.
- The controller does no arithmetic. Saturation and zero-extension of the bias are MAC behaviour.
- RD_ADDR never exceeds len-1, so the address does not wrap.

Optional Feature:
MAC_SEQ_CTRL_SAT_FLAG_EN
- Defined:
  - Adds output SAT_FLAG (1 bit, reset 0).
  - In CAPTURE, SAT_FLAG <= (MAC_Y==16'h7FFF || MAC_Y==16'h8000).
  - SAT_FLAG is valid alongside RESULT and is cleared when the next job is accepted.
- Undefined: the port is absent and all other behaviour is identical.

Test Plan:
- LEN=3, BIAS=5, A={2,3,4}, B={10,-7,5} -> RESULT=0x0018 (24), RESULT_VALID first high 6 cycles after START, RD_ADDR sequence 0,1,2.
- LEN=0, BIAS=0xC8 -> RESULT=0x00C8, RESULT_VALID at cycle 3, RD_EN never asserted.
- LEN=16, all A=127, B=127, BIAS=0 -> RESULT=0x7FFF, SAT_FLAG=1 if enabled. Repeat with A=-128, B=127 -> RESULT=0x8000.
- LEN=20 with VEC_LEN=16 -> exactly 16 ACCUM cycles, max RD_ADDR=15. START pulsed mid-ACCUM -> ignored, result unchanged.
- RESULT_READY held low 5 cycles -> RESULT/RESULT_VALID stable. RESULT_READY=1 with START=1 in HOLD -> LOAD next cycle, BUSY stays high.
- RST_N=0 during ACCUM idx=2 -> next cycle IDLE, BUSY=0, EN_MAC=0, RESULT=0, no RESULT_VALID.

Source files
------------

// File: rtl/mac_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// mac_seq_ctrl_if
// Bundles every signal between the MAC sequencer and its neighbours: the
// layer scheduler (START/LEN/BIAS, RESULT handshake), the shared operand RAM
// (RD_*) and the MAC lane (EN_MAC/RST_MAC/BIAS_OUT/A_OUT/B_OUT/MAC_Y).
//
// Modports
//   slave  : the sequencer (mac_seq_ctrl) itself
//   master : the surrounding environment (scheduler, RAM, MAC lane)
//
// Optional build macro: MAC_SEQ_CTRL_SAT_FLAG_EN adds SAT_FLAG.
// ---------------------------------------------------------------------------
interface mac_seq_ctrl_if #(
   parameter int ADDR_W = 4
);
   // scheduler side
   logic              START;
   logic [ADDR_W:0]   LEN;
   logic [7:0]        BIAS;
   logic              BUSY;
   logic [15:0]       RESULT;
   logic              RESULT_VALID;
   logic              RESULT_READY;
`ifdef MAC_SEQ_CTRL_SAT_FLAG_EN
   logic              SAT_FLAG;
`endif
   // operand RAM side
   logic              RD_EN;
   logic [ADDR_W-1:0] RD_ADDR;
   logic [7:0]        RD_A;
   logic [7:0]        RD_B;
   // MAC lane side
   logic              EN_MAC;
   logic              RST_MAC;
   logic [7:0]        BIAS_OUT;
   logic [7:0]        A_OUT;
   logic [7:0]        B_OUT;
   logic [15:0]       MAC_Y;

   modport slave (
      input  START, LEN, BIAS, RESULT_READY, RD_A, RD_B, MAC_Y,
      output BUSY, RESULT, RESULT_VALID, RD_EN, RD_ADDR,
      output EN_MAC, RST_MAC, BIAS_OUT, A_OUT,
`ifdef MAC_SEQ_CTRL_SAT_FLAG_EN
      output SAT_FLAG,
`endif
      output B_OUT
   );

   modport master (
      output START, LEN, BIAS, RESULT_READY, RD_A, RD_B, MAC_Y,
      input  BUSY, RESULT, RESULT_VALID, RD_EN, RD_ADDR,
      input  EN_MAC, RST_MAC, BIAS_OUT, A_OUT,
`ifdef MAC_SEQ_CTRL_SAT_FLAG_EN
      input  SAT_FLAG,
`endif
      input  B_OUT
   );
endinterface

// File: rtl/mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mac_seq_ctrl
// Sequencer for one 8x8 MAC lane with a saturating 16-bit accumulator. Each
// accepted START runs one biased dot product: one bias-load cycle, then len
// accumulate cycles fed from a 1-cycle-latency operand RAM, then the MAC
// output is captured and offered on a valid/ready result port.
//
// Ports
//   CLKEXT : clock, rising edge
//   RST_N  : synchronous active-low reset
//   bus    : mac_seq_ctrl_if.slave (scheduler, operand RAM and MAC signals)
//
// Parameters
//   VEC_LEN : maximum dot-product length; larger LEN values are clamped
//   ADDR_W  : operand RAM address width (VEC_LEN <= 2**ADDR_W); must match
//             the ADDR_W of the connected interface instance
//
// Optional build macro: MAC_SEQ_CTRL_SAT_FLAG_EN adds SAT_FLAG, set in
// CAPTURE when the MAC output sits at either saturation rail.
//
// Control outputs are registered: they are computed from the next state so
// that during each state they already hold that state's values. A_OUT/B_OUT
// are the only combinational outputs; RAM data arrives one cycle after the
// read strobe and is forwarded straight to the MAC in ACCUM.
// ---------------------------------------------------------------------------
module mac_seq_ctrl #(
   parameter int VEC_LEN = 16,
   parameter int ADDR_W  = 4
) (
   input logic           CLKEXT,
   input logic           RST_N,
   mac_seq_ctrl_if.slave bus
);

   localparam logic [ADDR_W:0] VEC_LEN_C = (ADDR_W+1)'(VEC_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ACCUM,
      S_CAPTURE,
      S_HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [ADDR_W:0]   idx_nxt;
   logic [7:0]        bias_q, bias_d;
   logic [15:0]       result_q, result_d;

   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              en_mac_q, en_mac_d;
   logic              rst_mac_q, rst_mac_d;
   logic [7:0]        bias_out_q, bias_out_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
`ifdef MAC_SEQ_CTRL_SAT_FLAG_EN
   logic              sat_q, sat_d;
`endif

   logic              accept;

   // A new job is taken in IDLE, or in HOLD when the pending result is being
   // handed off in the same cycle (back-to-back operation).
   always_comb begin
      accept = bus.START &&
               ((state_q == S_IDLE) || ((state_q == S_HOLD) && bus.RESULT_READY));
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath-register logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case statement can leave a value unassigned (no latches).
      state_d  = state_q;
      len_d    = len_q;
      idx_d    = idx_q;
      bias_d   = bias_q;
      result_d = result_q;
`ifdef MAC_SEQ_CTRL_SAT_FLAG_EN
      sat_d    = sat_q;
`endif

      case (state_q)
         S_IDLE: begin
            state_d = S_IDLE;
         end
         S_LOAD: begin
            idx_d   = '0;
            state_d = (len_q != '0) ? S_ACCUM : S_CAPTURE;
         end
         S_ACCUM: begin
            // idx < len <= VEC_LEN, so idx+1 fits in ADDR_W+1 bits.
            if ((idx_q + 1'b1) >= len_q) begin
               state_d = S_CAPTURE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_CAPTURE: begin
            result_d = bus.MAC_Y;
`ifdef MAC_SEQ_CTRL_SAT_FLAG_EN
            sat_d    = (bus.MAC_Y == 16'h7FFF) || (bus.MAC_Y == 16'h8000);
`endif
            state_d  = S_HOLD;
         end
         S_HOLD: begin
            if (bus.RESULT_READY) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Job acceptance overrides the per-state decision above.
      if (accept) begin
         state_d = S_LOAD;
         len_d   = (bus.LEN > VEC_LEN_C) ? VEC_LEN_C : bus.LEN;
         bias_d  = bus.BIAS;
         idx_d   = '0;
`ifdef MAC_SEQ_CTRL_SAT_FLAG_EN
         sat_d   = 1'b0;
`endif
      end
   end

   // -------------------------------------------------------------------------
   // Registered-output decode from the next state
   // -------------------------------------------------------------------------
   always_comb begin
      idx_nxt    = idx_d + 1'b1;
      en_mac_d   = (state_d == S_LOAD) || (state_d == S_ACCUM);
      rst_mac_d  = (state_d == S_LOAD);
      bias_out_d = (state_d == S_LOAD) ? bias_d : 8'h00;
      // LOAD prefetches operand 0; each ACCUM cycle prefetches the next one
      // while one remains, so RD_ADDR never goes past len-1.
      rd_en_d    = ((state_d == S_LOAD) && (len_d != '0)) ||
                   ((state_d == S_ACCUM) && (idx_nxt < len_d));
      rd_addr_d  = ((state_d == S_ACCUM) && rd_en_d) ? idx_nxt[ADDR_W-1:0] : '0;
      busy_d     = (state_d != S_IDLE);
      valid_d    = (state_d == S_HOLD);
   end

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge CLKEXT) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of the others.
      if (!RST_N) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         idx_q      <= '0;
         bias_q     <= '0;
         result_q   <= '0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         en_mac_q   <= 1'b0;
         rst_mac_q  <= 1'b0;
         bias_out_q <= '0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
`ifdef MAC_SEQ_CTRL_SAT_FLAG_EN
         sat_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         bias_q     <= bias_d;
         result_q   <= result_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         en_mac_q   <= en_mac_d;
         rst_mac_q  <= rst_mac_d;
         bias_out_q <= bias_out_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
`ifdef MAC_SEQ_CTRL_SAT_FLAG_EN
         sat_q      <= sat_d;
`endif
      end
   end

   // -------------------------------------------------------------------------
   // Output wiring
   // -------------------------------------------------------------------------
   assign bus.RD_EN        = rd_en_q;
   assign bus.RD_ADDR      = rd_addr_q;
   assign bus.EN_MAC       = en_mac_q;
   assign bus.RST_MAC      = rst_mac_q;
   assign bus.BIAS_OUT     = bias_out_q;
   assign bus.BUSY         = busy_q;
   assign bus.RESULT       = result_q;
   assign bus.RESULT_VALID = valid_q;
   assign bus.A_OUT        = (state_q == S_ACCUM) ? bus.RD_A : 8'h00;
   assign bus.B_OUT        = (state_q == S_ACCUM) ? bus.RD_B : 8'h00;
`ifdef MAC_SEQ_CTRL_SAT_FLAG_EN
   assign bus.SAT_FLAG     = sat_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_seq_ctrl
// Directed bench for mac_seq_ctrl. Surrounds the sequencer with a small
// operand RAM (1-cycle read latency) and a behavioural saturating MAC lane,
// then runs hand-computed dot products and handshake/reset scenarios.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mac_seq_ctrl;

   logic clk;
   logic rst_n;

   int total = 0;
   int bad   = 0;

   mac_seq_ctrl_if #(.ADDR_W(4)) bus ();

   mac_seq_ctrl #(.VEC_LEN(16), .ADDR_W(4)) dut (
      .CLKEXT (clk),
      .RST_N  (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- operand RAM model ----------------
   logic [7:0] ram_a [16];
   logic [7:0] ram_b [16];

   always @(posedge clk) begin
      if (bus.RD_EN) begin
         bus.RD_A <= ram_a[bus.RD_ADDR];
         bus.RD_B <= ram_b[bus.RD_ADDR];
      end
   end

   // ---------------- MAC lane model ----------------
   logic signed [15:0] acc;

   function automatic logic [15:0] sat16(input int v);
      if (v > 32767)  return 16'h7FFF;
      if (v < -32768) return 16'h8000;
      return v[15:0];
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (bus.EN_MAC) begin
         if (bus.RST_MAC) acc <= {8'h00, bus.BIAS_OUT};
         else acc <= sat16(int'(acc) + int'($signed(bus.A_OUT)) * int'($signed(bus.B_OUT)));
      end
   end

   assign bus.MAC_Y = acc;

   // ---------------- monitors ----------------
   int         rd_cnt = 0;
   int         acc_cnt = 0;
   logic [3:0] addr_log [64];

   always @(posedge clk) begin
      if (bus.RD_EN) begin
         addr_log[rd_cnt[5:0]] <= bus.RD_ADDR;
         rd_cnt <= rd_cnt + 1;
      end
      if (bus.EN_MAC && !bus.RST_MAC) acc_cnt <= acc_cnt + 1;
   end

   int rd_base;
   int acc_base;

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for RESULT_VALID; cyc0 is the number of cycles already elapsed
   // since the START cycle. Optionally pulses START mid-ACCUM.
   task automatic wait_valid(input int cyc0, input int exp_lat, input string tag, input bit pulse);
      int cyc;
      cyc = cyc0;
      while (!bus.RESULT_VALID && cyc < 100) begin
         if (pulse && cyc == 4) begin
            bus.START = 1'b1;
            bus.LEN   = 5'd1;
            bus.BIAS  = 8'hFF;
         end
         tick();
         cyc++;
         bus.START = 1'b0;
      end
      check({tag, "_lat"}, cyc, exp_lat);
   endtask

   task automatic run(input logic [4:0] len, input logic [7:0] bias, input logic [15:0] exp,
                      input int exp_lat, input string tag, input bit pulse);
      rd_base   = rd_cnt;
      acc_base  = acc_cnt;
      bus.LEN   = len;
      bus.BIAS  = bias;
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
      wait_valid(1, exp_lat, tag, pulse);
      check({tag, "_result"}, bus.RESULT, exp);
   endtask

   task automatic finish_job(input string tag);
      bus.RESULT_READY = 1'b1;
      tick();
      bus.RESULT_READY = 1'b0;
      check({tag, "_valid_drop"}, bus.RESULT_VALID, 0);
      check({tag, "_idle"}, bus.BUSY, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n            = 1'b0;
      bus.START        = 1'b0;
      bus.LEN          = '0;
      bus.BIAS         = '0;
      bus.RESULT_READY = 1'b0;
      bus.RD_A         = '0;
      bus.RD_B         = '0;
      for (int i = 0; i < 16; i++) begin
         ram_a[i] = '0;
         ram_b[i] = '0;
      end
      repeat (3) tick();

      // Reset state
      check("rst_busy", bus.BUSY, 0);
      check("rst_valid", bus.RESULT_VALID, 0);
      check("rst_result", bus.RESULT, 0);
      check("rst_en_mac", bus.EN_MAC, 0);
      check("rst_rd_en", bus.RD_EN, 0);
      check("rst_bias_out", bus.BIAS_OUT, 0);
      rst_n = 1'b1;
      tick();

      // LEN=3, BIAS=5: 5 + 2*10 + 3*(-7) + 4*5 = 24
      ram_a[0] = 8'd2;  ram_b[0] = 8'd10;
      ram_a[1] = 8'd3;  ram_b[1] = 8'hF9;
      ram_a[2] = 8'd4;  ram_b[2] = 8'd5;
      run(5'd3, 8'd5, 16'h0018, 6, "dot3", 1'b0);
      check("dot3_reads", rd_cnt - rd_base, 3);
      check("dot3_accums", acc_cnt - acc_base, 3);
      check("dot3_addr0", addr_log[rd_base % 64], 0);
      check("dot3_addr1", addr_log[(rd_base + 1) % 64], 1);
      check("dot3_addr2", addr_log[(rd_base + 2) % 64], 2);
`ifdef MAC_SEQ_CTRL_SAT_FLAG_EN
      check("dot3_sat", bus.SAT_FLAG, 0);
`endif
      finish_job("dot3");

      // LEN=0: bias only
      run(5'd0, 8'hC8, 16'h00C8, 3, "bias_only", 1'b0);
      check("bias_only_reads", rd_cnt - rd_base, 0);
      check("bias_only_accums", acc_cnt - acc_base, 0);
      finish_job("bias_only");

      // Positive saturation: 16 * 127*127 clamps to 0x7FFF
      for (int i = 0; i < 16; i++) begin
         ram_a[i] = 8'd127;
         ram_b[i] = 8'd127;
      end
      run(5'd16, 8'd0, 16'h7FFF, 19, "sat_pos", 1'b0);
      check("sat_pos_accums", acc_cnt - acc_base, 16);
`ifdef MAC_SEQ_CTRL_SAT_FLAG_EN
      check("sat_pos_flag", bus.SAT_FLAG, 1);
`endif
      finish_job("sat_pos");

      // Negative saturation: 16 * (-128*127) clamps to 0x8000
      for (int i = 0; i < 16; i++) ram_a[i] = 8'h80;
      run(5'd16, 8'd0, 16'h8000, 19, "sat_neg", 1'b0);
`ifdef MAC_SEQ_CTRL_SAT_FLAG_EN
      check("sat_neg_flag", bus.SAT_FLAG, 1);
`endif
      finish_job("sat_neg");

      // LEN=20 clamps to 16; START pulsed mid-ACCUM is ignored.
      // 4 + sum(1..16) = 140
      for (int i = 0; i < 16; i++) begin
         ram_a[i] = 8'd1;
         ram_b[i] = 8'(i + 1);
      end
      run(5'd20, 8'd4, 16'h008C, 19, "clamp", 1'b1);
      check("clamp_accums", acc_cnt - acc_base, 16);
      check("clamp_reads", rd_cnt - rd_base, 16);
      check("clamp_max_addr", addr_log[(rd_base + 15) % 64], 15);
      finish_job("clamp");

      // Result held while RESULT_READY is low: 1 + 1*1 + 1*2 = 4
      run(5'd2, 8'd1, 16'h0004, 5, "hold", 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_result", bus.RESULT, 16'h0004);
         check("hold_valid", bus.RESULT_VALID, 1);
      end

      // Back-to-back: handshake and new START together -> LOAD next cycle
      bus.LEN          = 5'd1;
      bus.BIAS         = 8'h10;
      bus.RESULT_READY = 1'b1;
      bus.START        = 1'b1;
      tick();
      bus.RESULT_READY = 1'b0;
      bus.START        = 1'b0;
      check("b2b_busy", bus.BUSY, 1);
      check("b2b_load", bus.RST_MAC, 1);
      check("b2b_valid", bus.RESULT_VALID, 0);
      wait_valid(1, 4, "b2b", 1'b0);
      check("b2b_result", bus.RESULT, 16'h0011);
      finish_job("b2b");

      // Reset during ACCUM idx=2 abandons the job
      bus.LEN   = 5'd5;
      bus.BIAS  = 8'd3;
      bus.START = 1'b1;
      tick();                 // LOAD
      bus.START = 1'b0;
      tick();                 // ACCUM idx0
      tick();                 // ACCUM idx1
      tick();                 // ACCUM idx2
      check("mid_accum_busy", bus.BUSY, 1);
      rst_n = 1'b0;
      tick();
      check("rstmid_busy", bus.BUSY, 0);
      check("rstmid_en_mac", bus.EN_MAC, 0);
      check("rstmid_result", bus.RESULT, 0);
      check("rstmid_valid", bus.RESULT_VALID, 0);
      rst_n = 1'b1;
      repeat (8) tick();
      check("rstmid_no_valid", bus.RESULT_VALID, 0);
      check("rstmid_stay_idle", bus.BUSY, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
